if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, max granted-but-unanswered memory requests (1..DEPTH).
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_  input  1  asynchronous active-low reset.
REQ-007 SHALL have ports stall  input  1  decode not accepting; flush  input  1  pipeline flush; pc_flush  input  XLEN  flush target.
REQ-008 SHALL have ports branch  input  1  taken branch; pc_branch  input  XLEN  branch target.
REQ-009 SHALL have ports imem_req  output  1; imem_addr  output  XLEN; imem_gnt  input  1; imem_rvalid  input  1; imem_rdata  input  XLEN.
REQ-010 SHALL have ports pc  output  XLEN; instruction  output  XLEN; valid  output  1  head entry to decode.

Function
REQ-011 SHALL assert imem_req with imem_addr=fetch_pc when (occupancy+outstanding)<DEPTH, outstanding<MAX_OUTSTANDING, and no redirect this cycle.
REQ-012 SHALL count a request as issued when imem_req&&imem_gnt; fetch_pc SHALL then advance by 4 and the issued address SHALL be pushed into an in-flight PC FIFO of MAX_OUTSTANDING entries.
REQ-013 SHALL treat responses as in order; each non-discarded imem_rvalid SHALL pair imem_rdata with the oldest in-flight PC and push {pc,instr} into the queue.
REQ-014 SHALL drive valid=1 when the queue is non-empty, pc/instruction from the head; head SHALL pop when valid&&!stall.
REQ-015 SHALL drive pc=0 and instruction=0 whenever valid=0.
REQ-016 SHALL never overflow: credit rule REQ-011 guarantees space; push and pop in the same cycle SHALL be legal at any occupancy.
REQ-017 SHALL treat flush or branch as a redirect, flush having priority; target = pc_flush or pc_branch with bits [1:0] forced to 0.
REQ-018 On redirect in cycle N: queue emptied, in-flight PC FIFO emptied, fetch_pc=target, discard counter=outstanding (including a grant in cycle N), valid=0 in N+1, imem_req may assert for target from N+1.
REQ-019 SHALL drop, without pushing, exactly as many subsequent imem_rvalid beats as the discard counter holds, decrementing per beat; an imem_rvalid in cycle N itself SHALL also be dropped.
REQ-020 SHALL deassert imem_req during a redirect cycle; an ungranted request MAY be withdrawn or change address.
REQ-021 Redirect SHALL override stall; stall SHALL never block redirect or memory acceptance.
REQ-022 fetch_pc SHALL wrap modulo 2^XLEN without error.
REQ-023 Without bypass, latency SHALL be imem_rvalid in cycle N -> valid in N+1 when the queue was empty.

Reset
REQ-024 rst_ low SHALL immediately set fetch_pc=RESET_PC, queue, in-flight FIFO, outstanding and discard counters to empty/0, valid=0, imem_req=0, pc=0, instruction=0.
REQ-025 Reset mid-operation SHALL abandon all in-flight requests; the memory is reset with the same rst_, so no discard is carried.
REQ-026 First imem_req SHALL assert in the first cycle after rst_ deasserts, addr=RESET_PC.

Configuration
REQ-027 Macro IFQ_BYPASS_EN defined: when the queue is empty and a non-discarded imem_rvalid arrives, pc/instruction/valid SHALL reflect it combinationally in the same cycle; if !stall the entry SHALL not enter the queue.
REQ-028 Macro IFQ_BYPASS_EN undefined: all responses SHALL pass through the queue (REQ-023 latency); no combinational path from imem_* to valid.

Verification (DEPTH=4, MAX_OUTSTANDING=2, RESET_PC=0, memory: gnt=1, rvalid 1 cycle after grant, rdata=addr|32'h13)
REQ-029 Reset release, stall=0 -> imem_addr 0,4,8,... each cycle; valid from 2nd cycle after grant (bypass off) with pc=0,instr=0x13, then pc=4,instr=0x17.
REQ-030 stall=1 for 6 cycles -> occupancy reaches 4, imem_req=0, pc held constant; release -> 4 pops in 4 cycles, no entry lost or duplicated.
REQ-031 flush=1, pc_flush=0x40 with 2 outstanding -> next cycle valid=0, 2 responses dropped, first valid pc=0x40, instr=0x53.
REQ-032 flush=1 pc_flush=0x40 and branch=1 pc_branch=0x80 same cycle -> fetch resumes at 0x40; branch alone pc_branch=0x83 -> resumes at 0x80.
REQ-033 Memory gnt randomly low, rvalid delayed 3 cycles -> outstanding never exceeds 2, pc sequence strictly +4, instruction matches pc|0x13.
REQ-034 IFQ_BYPASS_EN defined, queue empty -> valid in the same cycle as imem_rvalid with pc=imem_addr of that request.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end with credit-limited memory requests,
// an in-flight PC FIFO and a fetch queue. Define IFQ_BYPASS_EN for same-cycle response bypass.
module if_fetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_flush,
    input  logic            branch,
    input  logic [XLEN-1:0] pc_branch,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instruction,
    output logic            valid
);
    localparam int unsigned QW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned SW = CW + 2;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
    localparam logic [IW-1:0] I_LAST  = IW'(MAX_OUTSTANDING - 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] qpc_q  [DEPTH];
    logic [XLEN-1:0] qpc_d  [DEPTH];
    logic [XLEN-1:0] qins_q [DEPTH];
    logic [XLEN-1:0] qins_d [DEPTH];
    logic [QW-1:0]   q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [CW-1:0]   q_cnt_q, q_cnt_d;
    logic [XLEN-1:0] ipc_q  [MAX_OUTSTANDING];
    logic [XLEN-1:0] ipc_d  [MAX_OUTSTANDING];
    logic [IW-1:0]   i_rd_q, i_rd_d, i_wr_q, i_wr_d;
    logic [CW-1:0]   i_cnt_q, i_cnt_d;
    logic [CW-1:0]   disc_q, disc_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [SW-1:0]   credit_used;
    logic            issue, drop, accept, bypass, push, pop, q_empty;

    function automatic logic [IW-1:0] next_i(input logic [IW-1:0] p);
        return (p == I_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        redirect    = flush || branch;
        target      = flush ? pc_flush : pc_branch;
        target[1:0] = 2'b00;
        // Discarded beats still occupy the memory, so they count against both credits.
        outstanding = i_cnt_q + disc_q;
        credit_used = SW'(q_cnt_q) + SW'(outstanding);
        imem_req    = rst_ && !redirect && (credit_used < DEPTH_S) && (outstanding < MAXO_C);
        imem_addr   = fetch_pc_q;
        issue       = imem_req && imem_gnt;
        drop        = redirect || (disc_q != '0);
        accept      = imem_rvalid && !drop;
        q_empty     = (q_cnt_q == '0);
`ifdef IFQ_BYPASS_EN
        bypass      = accept && q_empty;
`else
        bypass      = 1'b0;
`endif
        push        = accept && !(bypass && !stall);
        pop         = !q_empty && !stall && !redirect;
    end

    always_comb begin
        valid       = 1'b0;
        pc          = '0;
        instruction = '0;
        if (!q_empty) begin
            valid       = 1'b1;
            pc          = qpc_q[q_rd_q];
            instruction = qins_q[q_rd_q];
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass) begin
            valid       = 1'b1;
            pc          = ipc_q[i_rd_q];
            instruction = imem_rdata;
        end
`endif
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        qpc_d      = qpc_q;
        qins_d     = qins_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;
        q_cnt_d    = q_cnt_q;
        ipc_d      = ipc_q;
        i_rd_d     = i_rd_q;
        i_wr_d     = i_wr_q;
        i_cnt_d    = i_cnt_q;
        disc_d     = disc_q;
        if (redirect) begin
            fetch_pc_d = target;
            q_rd_d     = '0;
            q_wr_d     = '0;
            q_cnt_d    = '0;
            i_rd_d     = '0;
            i_wr_d     = '0;
            i_cnt_d    = '0;
            // Everything still owed by memory is discarded; a beat arriving now is one of them.
            disc_d     = outstanding + CW'(issue);
            if (imem_rvalid && (disc_d != '0))
                disc_d = disc_d - 1'b1;
        end else begin
            if (issue) begin
                ipc_d[i_wr_q] = fetch_pc_q;
                i_wr_d        = next_i(i_wr_q);
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
            end
            if (accept)
                i_rd_d = next_i(i_rd_q);
            i_cnt_d = i_cnt_q + CW'(issue) - CW'(accept);
            if (imem_rvalid && (disc_q != '0))
                disc_d = disc_q - 1'b1;
            if (push) begin
                qpc_d[q_wr_q]  = ipc_q[i_rd_q];
                qins_d[q_wr_q] = imem_rdata;
                q_wr_d         = q_wr_q + 1'b1;
            end
            if (pop)
                q_rd_d = q_rd_q + 1'b1;
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fetch_pc_q <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                qpc_q[i]  <= '0;
                qins_q[i] <= '0;
            end
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++)
                ipc_q[i] <= '0;
            q_rd_q  <= '0;
            q_wr_q  <= '0;
            q_cnt_q <= '0;
            i_rd_q  <= '0;
            i_wr_q  <= '0;
            i_cnt_q <= '0;
            disc_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            qpc_q      <= qpc_d;
            qins_q     <= qins_d;
            ipc_q      <= ipc_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            q_cnt_q    <= q_cnt_d;
            i_rd_q     <= i_rd_d;
            i_wr_q     <= i_wr_d;
            i_cnt_q    <= i_cnt_d;
            disc_q     <= disc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model and an in-order memory model.
module tb_if_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, branch = 1'b0;
    logic [31:0] pc_flush = '0, pc_branch = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc, instruction;
    logic        valid;

    if_fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .rst_(rst_), .stall(stall), .flush(flush), .pc_flush(pc_flush),
        .branch(branch), .pc_branch(pc_branch), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .instruction(instruction), .valid(valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0] m_fetch = RPC;
    logic [31:0] m_qpc[$];
    logic [31:0] m_qin[$];
    logic [31:0] m_infl[$];
    int          m_disc = 0;
    // memory model state
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          cyc = 0;
    int          lat = 1;
    int          gnt_pct = 100;

    task automatic step(input logic s, input logic f, input logic [31:0] fpc,
                        input logic b, input logic [31:0] bpc);
        logic        e_req, e_valid, byp, accept, issued, rv, s_req;
        logic [31:0] e_pc, e_ins, rd, s_addr, p;
        int          rem;
        stall = s; flush = f; pc_flush = fpc; branch = b; pc_branch = bpc;
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = 1'b0;
        rd = 32'hdead_beef;
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            rv = 1'b1;
            rd = mem_addr[0] | 32'h13;
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        #1;
        e_req = !(f || b) && (m_qpc.size() + m_infl.size() + m_disc < DEPTH)
                && (m_infl.size() + m_disc < MAXO);
        accept = rv && !(f || b) && (m_disc == 0);
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = accept && (m_qpc.size() == 0);
`endif
        e_valid = 1'b0; e_pc = '0; e_ins = '0;
        if (m_qpc.size() > 0) begin
            e_valid = 1'b1; e_pc = m_qpc[0]; e_ins = m_qin[0];
        end else if (byp && m_infl.size() > 0) begin
            e_valid = 1'b1; e_pc = m_infl[0]; e_ins = rd;
        end
        check("imem_req", 32'(imem_req), 32'(e_req));
        if (e_req) check("imem_addr", imem_addr, m_fetch);
        check("valid", 32'(valid), 32'(e_valid));
        check("pc", pc, e_pc);
        check("instruction", instruction, e_ins);
        check("outstanding_le_max", 32'(mem_addr.size() <= MAXO), 32'd1);
        s_req  = imem_req;
        s_addr = imem_addr;
        @(posedge clk);
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (s_req && imem_gnt) begin
            mem_addr.push_back(s_addr);
            mem_due.push_back(cyc + lat);
        end
        cyc++;
        issued = e_req && imem_gnt;
        if (f || b) begin
            rem = m_infl.size() + m_disc + int'(issued) - int'(rv);
            m_infl.delete(); m_qpc.delete(); m_qin.delete();
            m_disc  = (rem < 0) ? 0 : rem;
            m_fetch = (f ? fpc : bpc) & ~32'h3;
        end else begin
            if (m_qpc.size() > 0 && !s) begin
                void'(m_qpc.pop_front());
                void'(m_qin.pop_front());
            end
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else if (m_infl.size() > 0) begin
                    p = m_infl.pop_front();
                    if (!(byp && !s)) begin
                        m_qpc.push_back(p);
                        m_qin.push_back(rd);
                    end
                end
            end
            if (issued) begin
                m_infl.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_ = 1'b0;
        flush = 1'b0; branch = 1'b0; stall = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        m_fetch = RPC; m_disc = 0;
        m_qpc.delete(); m_qin.delete(); m_infl.delete();
        mem_addr.delete(); mem_due.delete();
        @(posedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic run(input int n, input int stall_pct, input int redir_pct);
        logic f, b;
        for (int i = 0; i < n; i++) begin
            f = ($urandom_range(99) < redir_pct);
            b = ($urandom_range(99) < redir_pct);
            step($urandom_range(99) < stall_pct, f, $urandom(), b, $urandom());
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        lat = 1; gnt_pct = 100;
        run(12, 0, 0);
        repeat (6) step(1'b1, 1'b0, '0, 1'b0, '0);
        run(8, 0, 0);
        lat = 3;
        run(6, 0, 0);
        step(1'b0, 1'b1, 32'h40, 1'b0, '0);
        run(10, 0, 0);
        step(1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        run(8, 0, 0);
        lat = 1;
        step(1'b1, 1'b0, '0, 1'b1, 32'h83);
        run(8, 0, 0);
        step(1'b0, 1'b0, '0, 1'b1, 32'hffff_fff8);
        run(8, 20, 0);
        lat = 3; gnt_pct = 60;
        run(600, 30, 3);
        do_reset();
        lat = 1; gnt_pct = 100;
        run(20, 0, 0);
        lat = 2; gnt_pct = 80;
        run(300, 40, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
